// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer slice.
//   - pc_sel encodings driven by decode/control
//   - sequencer state enum
//   - default reset / exception vectors
package pc_sequencer_pkg;

    localparam logic [2:0] PC_SEL_SEQ    = 3'd0;
    localparam logic [2:0] PC_SEL_BRANCH = 3'd1;
    localparam logic [2:0] PC_SEL_JUMP   = 3'd2;
    localparam logic [2:0] PC_SEL_JR     = 3'd3;

    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_0004;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_HALT
    } seq_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bus bundle between the sequencer, the PC register and instruction memory.
//   imem_req/imem_addr/imem_ready : fetch handshake
//   pc_q/pc_ena/pc_next           : PC register read-back, enable, data in
// master = sequencer side, slave = PC register / imem side.
interface pc_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] pc_q;
    logic        pc_ena;
    logic [31:0] pc_next;

    modport master (
        output imem_req, imem_addr, pc_ena, pc_next,
        input  imem_ready, pc_q
    );

    modport slave (
        input  imem_req, imem_addr, pc_ena, pc_next,
        output imem_ready, pc_q
    );
endinterface

// File: rtl/pc_sequencer_pc_next_mux.sv
// pc_next_mux: combinational next-PC selection with priority
//   exc_req > eret > misaligned jr > pc_sel (branch/jump/jr/seq).
// Ports:
//   pc_q, pc_sel, branch_taken, branch_off, jump_idx, jr_addr,
//   exc_req, eret, epc : selection inputs
//   pc_next            : selected next PC
//   save_epc           : this commit traps, epc must capture pc_q
module pc_next_mux
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] EXC_VEC = EXC_VEC_DEF
) (
    input  logic [31:0] pc_q,
    input  logic [2:0]  pc_sel,
    input  logic        branch_taken,
    input  logic [31:0] branch_off,
    input  logic [25:0] jump_idx,
    input  logic [31:0] jr_addr,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] pc_next,
    output logic        save_epc
);

    logic [31:0] pc4;
    logic        jr_misaligned;

    assign pc4           = pc_q + 32'd4;
    assign jr_misaligned = (pc_sel == PC_SEL_JR) && (jr_addr[1:0] != 2'b00);

    always_comb begin
        pc_next  = pc4;
        save_epc = 1'b0;
        if (exc_req) begin
            pc_next  = EXC_VEC;
            save_epc = 1'b1;
        end else if (eret) begin
            pc_next = epc;
        end else if (jr_misaligned) begin
            // A misaligned register jump is treated as an address exception
            pc_next  = EXC_VEC;
            save_epc = 1'b1;
        end else begin
            case (pc_sel)
                PC_SEL_BRANCH: pc_next = branch_taken ? (pc4 + branch_off) : pc4;
                PC_SEL_JUMP:   pc_next = {pc4[31:28], jump_idx, 2'b00};
                PC_SEL_JR:     pc_next = jr_addr;
                default:       pc_next = pc4;
            endcase
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/commit controller for the program counter.
// Ports:
//   clk, rst         : clock, async active-high reset
//   bus (master)     : imem handshake + PC register interface
//   instr_valid      : one-cycle commit strobe
//   pc_sel, branch_taken, branch_off, jump_idx, jr_addr : next-PC controls
//   exc_req, eret    : exception entry / return
//   epc              : saved exception PC
//   halt_req, step   : debug halt level and single-step pulse
//   halted, retired  : debug status and committed-instruction count
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
    parameter logic [31:0] EXC_VEC   = EXC_VEC_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    pc_sequencer_if.master        bus,
    output logic                  instr_valid,
    input  logic [2:0]            pc_sel,
    input  logic                  branch_taken,
    input  logic [31:0]           branch_off,
    input  logic [25:0]           jump_idx,
    input  logic [31:0]           jr_addr,
    input  logic                  exc_req,
    input  logic                  eret,
    output logic [31:0]           epc,
    input  logic                  halt_req,
    input  logic                  step,
    output logic                  halted,
    output logic [31:0]           retired
);

    seq_state_e  state, state_nxt;
    logic        step_mode, step_mode_nxt;
    logic        exec;
    logic [31:0] mux_pc;
    logic        save_epc;

    pc_next_mux #(.EXC_VEC(EXC_VEC)) u_mux (
        .pc_q         (bus.pc_q),
        .pc_sel       (pc_sel),
        .branch_taken (branch_taken),
        .branch_off   (branch_off),
        .jump_idx     (jump_idx),
        .jr_addr      (jr_addr),
        .exc_req      (exc_req),
        .eret         (eret),
        .epc          (epc),
        .pc_next      (mux_pc),
        .save_epc     (save_epc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            step_mode <= 1'b0;
        end else begin
            state     <= state_nxt;
            step_mode <= step_mode_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        step_mode_nxt = step_mode;
        case (state)
            ST_IDLE:  state_nxt = ST_FETCH;
            ST_FETCH: if (bus.imem_ready) state_nxt = ST_EXEC;
            ST_EXEC: begin
                // A pending halt (or the end of a single step) parks after commit
                if (halt_req || step_mode) begin
                    state_nxt     = ST_HALT;
                    step_mode_nxt = 1'b0;
                end else begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_HALT: begin
                if (step) begin
                    state_nxt     = ST_FETCH;
                    step_mode_nxt = 1'b1;
                end else if (!halt_req) begin
                    state_nxt = ST_FETCH;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign exec          = (state == ST_EXEC);
    assign bus.imem_req  = (state == ST_FETCH);
    assign bus.imem_addr = bus.pc_q;
    assign bus.pc_ena    = exec;
    assign instr_valid   = exec;
    assign halted        = (state == ST_HALT);
    // Outside a commit the data input parks at the reset vector
    assign bus.pc_next   = exec ? mux_pc : RESET_VEC;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epc     <= 32'd0;
            retired <= 32'd0;
        end else if (exec) begin
            retired <= retired + 32'd1;
            if (save_epc) epc <= bus.pc_q;
        end
    end

endmodule
